morse_decoder: RTL and testbench

- Receive-side stage that sits directly downstream of the Morse flasher and consumes its serial pulse stream (the LED drive signal).
- Measures mark and space run lengths in clock cycles, classifies each mark as dot or dash, and assembles up to 4 symbols per letter.
- At the end of a letter, decodes the symbols back to the 3-bit letter selector the flasher uses (S,T,U,V,W,X,Y,Z = 0..7).
- Intended for loopback self-check on the board and in simulation.

---
 rtl/morse_decoder.sv | 158 +++++++++++++++
 tb/tb_morse_decoder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/morse_decoder.sv
// morse_decoder: receive side of the Morse flasher loopback.
// Times each mark and space in clock cycles, classifies marks as dot or dash,
// collects up to 4 symbols and decodes the letter back to the flasher's 3-bit
// selector (S..Z = 0..7) once a 2-unit space ends the letter.
//
// Ports:
//   clock         system clock, rising edge
//   reset         asynchronous active-high reset
//   morse_in      serial stream, 1 = mark, 0 = space
//   letter_code   last decoded letter, held until the next valid letter
//   letter_valid  one-cycle pulse when letter_code updates
//   error         one-cycle pulse when a letter is rejected
//   busy          high while a letter is in progress
//
// Build option: define MORSE_DECODER_SYNC_EN to put a two-flop synchroniser
// on morse_in (adds 2 cycles to every detection and latency figure).
module morse_decoder #(
  parameter int unsigned UNIT_CYCLES = 25_000_000  // even, >= 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       morse_in,
  output logic [2:0] letter_code,
  output logic       letter_valid,
  output logic       error,
  output logic       busy
);

  localparam int unsigned SAT = 4 * UNIT_CYCLES;
  localparam int unsigned CW  = $clog2(SAT + 1);

  localparam logic [CW-1:0] SAT_C  = CW'(SAT);
  localparam logic [CW-1:0] HALF_U = CW'(UNIT_CYCLES / 2);
  localparam logic [CW-1:0] TWO_U  = CW'(2 * UNIT_CYCLES);
  // cnt holds the number of lows already seen, so the 2U-th low arrives
  // while cnt == 2U-1.
  localparam logic [CW-1:0] END_C  = CW'(2 * UNIT_CYCLES - 1);
  localparam logic [CW-1:0] ONE    = CW'(1);

  typedef enum logic [1:0] {IDLE, MARK, SPACE} state_t;

  logic in_s;

`ifdef MORSE_DECODER_SYNC_EN
  logic [1:0] sync_q;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[0], morse_in};
  end
  assign in_s = sync_q[1];
`else
  assign in_s = morse_in;
`endif

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    nsym_q, nsym_d;
  logic [3:0]    pat_q, pat_d;   // first symbol ends up in the MSB side
  logic [2:0]    code_d;
  logic          valid_d, err_d;
  logic [3:0]    hit_code;       // {hit, code}

  // Pattern table; unused upper pattern bits are zero because pat is
  // cleared whenever a letter ends or is discarded.
  function automatic logic [3:0] lookup(input logic [2:0] n, input logic [3:0] p);
    case ({n, p})
      {3'd3, 4'b0000}: lookup = {1'b1, 3'd0};  // S ...
      {3'd1, 4'b0001}: lookup = {1'b1, 3'd1};  // T -
      {3'd3, 4'b0001}: lookup = {1'b1, 3'd2};  // U ..-
      {3'd4, 4'b0001}: lookup = {1'b1, 3'd3};  // V ...-
      {3'd3, 4'b0011}: lookup = {1'b1, 3'd4};  // W .--
      {3'd4, 4'b1001}: lookup = {1'b1, 3'd5};  // X -..-
      {3'd4, 4'b1011}: lookup = {1'b1, 3'd6};  // Y -.--
      {3'd4, 4'b1100}: lookup = {1'b1, 3'd7};  // Z --..
      default:         lookup = 4'b0000;
    endcase
  endfunction

  assign hit_code = lookup(nsym_q, pat_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    nsym_d  = nsym_q;
    pat_d   = pat_q;
    code_d  = letter_code;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_s) begin
          state_d = MARK;
          cnt_d   = ONE;
        end
      end
      MARK: begin
        if (in_s) begin
          if (cnt_q != SAT_C) cnt_d = cnt_q + ONE;
        end else if (cnt_q < HALF_U || cnt_q == SAT_C || nsym_q == 3'd4) begin
          // glitch, over-long mark or fifth symbol: drop the whole letter
          err_d   = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
          nsym_d  = '0;
          pat_d   = '0;
        end else begin
          pat_d   = {pat_q[2:0], (cnt_q >= TWO_U)};
          nsym_d  = nsym_q + 3'd1;
          state_d = SPACE;
          cnt_d   = ONE;
        end
      end
      SPACE: begin
        if (in_s) begin
          state_d = MARK;
          cnt_d   = ONE;
        end else if (cnt_q == END_C) begin
          if (hit_code[3]) begin
            code_d  = hit_code[2:0];
            valid_d = 1'b1;
          end else begin
            err_d   = 1'b1;
          end
          state_d = IDLE;
          cnt_d   = '0;
          nsym_d  = '0;
          pat_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      nsym_q       <= '0;
      pat_q        <= '0;
      letter_code  <= '0;
      letter_valid <= 1'b0;
      error        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      nsym_q       <= nsym_d;
      pat_q        <= pat_d;
      letter_code  <= code_d;
      letter_valid <= valid_d;
      error        <= err_d;
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_morse_decoder.sv
// Bench for morse_decoder at UNIT_CYCLES=8. Stimulus is a per-cycle bit
// stream; the reference model works on mark/space run lengths and Morse
// strings to predict every cycle's outputs.
module tb_morse_decoder;
  localparam int U = 8;
`ifdef MORSE_DECODER_SYNC_EN
  localparam int D = 2;
`else
  localparam int D = 0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       morse_in = 1'b0;
  logic [2:0] letter_code;
  logic       letter_valid, error, busy;

  morse_decoder #(.UNIT_CYCLES(U)) dut (
    .clock(clock), .reset(reset), .morse_in(morse_in),
    .letter_code(letter_code), .letter_valid(letter_valid),
    .error(error), .busy(busy)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  bit stim[$];
  int model_code = 0;

  typedef struct {
    string pat;
    int    code;
    bit    bad;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int morse_lookup(input string s);
    string t[8] = '{"...", "-", "..-", "...-", ".--", "-..-", "-.--", "--.."};
    for (int k = 0; k < 8; k++) if (s == t[k]) return k;
    return -1;
  endfunction

  task automatic push_run(input bit v, input int n);
    for (int k = 0; k < n; k++) stim.push_back(v);
  endtask

  // dot = 1 unit, dash = 3 units, 1-unit gaps, 20-cycle letter gap
  task automatic build_letter(input string p);
    for (int k = 0; k < p.len(); k++) begin
      push_run(1'b1, (p[k] == "-") ? 3*U : U);
      push_run(1'b0, (k == p.len()-1) ? 20 : U);
    end
  endtask

  // Predict outputs from run lengths, then drive stim and compare per cycle.
  task automatic run_stim(output int nv, output int ne, output int f_last, output int v_edge);
    int n = stim.size();
    bit ev[] = new[n];
    bit ee[] = new[n];
    bit eb[] = new[n];
    int vc[] = new[n];
    int ec[] = new[n];
    int i = 0, act = -1, s, f, len, gap, e, c, cur;
    string lt = "";
    nv = 0; ne = 0; f_last = -1; v_edge = -1;
    while (i < n) begin
      if (!stim[i]) begin i++; continue; end
      s = i;
      while (i < n && stim[i]) i++;
      len = i - s; f = i; f_last = f;
      if (act < 0) act = s;
      if (len < U/2 || len >= 4*U || lt.len() == 4) begin
        if (f+D < n) ee[f+D] = 1'b1;
        for (int k = act; k < f; k++) if (k+D < n) eb[k+D] = 1'b1;
        act = -1; lt = "";
        continue;
      end
      lt = {lt, (len >= 2*U) ? "-" : "."};
      while (i < n && !stim[i]) i++;
      gap = i - f;
      if (gap >= 2*U) begin
        e = f + 2*U - 1;
        c = morse_lookup(lt);
        if (e+D < n) begin
          if (c >= 0) begin ev[e+D] = 1'b1; vc[e+D] = c; end
          else ee[e+D] = 1'b1;
        end
        for (int k = act; k < e; k++) if (k+D < n) eb[k+D] = 1'b1;
        act = -1; lt = "";
      end
    end
    cur = model_code;
    for (int k = 0; k < n; k++) begin
      if (ev[k]) cur = vc[k];
      ec[k] = cur;
    end
    model_code = cur;
    for (int k = 0; k < n; k++) begin
      @(negedge clock) morse_in = stim[k];
      @(posedge clock);
      #1;
      check("cycle {valid,err,busy,code}",
            {letter_valid, error, busy, letter_code},
            {ev[k], ee[k], eb[k], ec[k][2:0]});
      if (letter_valid) begin nv++; if (v_edge < 0) v_edge = k; end
      if (error) ne++;
    end
    stim.delete();
  endtask

  task automatic drive_raw(input bit v, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clock) morse_in = v;
    end
  endtask

  initial begin
    vec_t tv[12];
    int nv, ne, fl, ve, held;
    tv[0]  = '{"...",   0, 1'b0};
    tv[1]  = '{"-",     1, 1'b0};
    tv[2]  = '{"--..",  7, 1'b0};
    tv[3]  = '{"..-",   2, 1'b0};
    tv[4]  = '{".....", 0, 1'b1};
    tv[5]  = '{".-",    0, 1'b1};
    tv[6]  = '{"...-",  3, 1'b0};
    tv[7]  = '{".--",   4, 1'b0};
    tv[8]  = '{"-..-",  5, 1'b0};
    tv[9]  = '{"-.--",  6, 1'b0};
    tv[10] = '{".",     0, 1'b1};
    tv[11] = '{"--",    0, 1'b1};

    repeat (3) @(posedge clock);
    #1 check("reset outputs", {letter_code, letter_valid, error, busy}, 0);
    @(negedge clock) reset = 1'b0;

    // S: latency from the last fall and busy release
    build_letter("...");
    run_stim(nv, ne, fl, ve);
    check("S valid count", nv, 1);
    check("S error count", ne, 0);
    check("S code", letter_code, 0);
    check("S latency", ve - fl + 1, 2*U + D);
    held = 0;

    // table of letters: one valid or one error each, code held on error
    for (int t = 0; t < 12; t++) begin
      build_letter(tv[t].pat);
      run_stim(nv, ne, fl, ve);
      check({"valid count ", tv[t].pat}, nv, tv[t].bad ? 0 : 1);
      check({"error count ", tv[t].pat}, ne, tv[t].bad ? 1 : 0);
      if (!tv[t].bad) held = tv[t].code;
      check({"code ", tv[t].pat}, letter_code, held);
    end

    // glitch, then over-long mark; both rejected, code unchanged
    push_run(1'b1, 2);  push_run(1'b0, 20);
    run_stim(nv, ne, fl, ve);
    check("glitch error", ne, 1);
    check("glitch valid", nv, 0);
    check("glitch busy", busy, 0);
    check("glitch code", letter_code, held);
    push_run(1'b1, 40); push_run(1'b0, 20);
    run_stim(nv, ne, fl, ve);
    check("long mark error", ne, 1);
    check("long mark code", letter_code, held);
    build_letter("..-");
    run_stim(nv, ne, fl, ve);
    check("U after errors", letter_code, 2);

    // mark arriving right on the re-arm cycle after a letter ends
    push_run(1'b1, U); push_run(1'b0, 2*U);
    push_run(1'b1, 3*U); push_run(1'b0, 20);
    run_stim(nv, ne, fl, ve);
    check("back-to-back valid count", nv, 1);
    check("back-to-back error count", ne, 1);

    // randomized run-length streams
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 25; k++) begin
        int len;
        case ($urandom_range(0, 5))
          0: len = $urandom_range(1, 5);
          1: len = $urandom_range(28, 40);
          2, 3: len = $urandom_range(4, 15);
          default: len = $urandom_range(14, 31);
        endcase
        push_run(1'b1, len);
        push_run(1'b0, ($urandom_range(0, 3) == 0) ? $urandom_range(14, 20) : $urandom_range(1, 12));
      end
      push_run(1'b0, 24);
      run_stim(nv, ne, fl, ve);
    end

    // reset in the middle of V's second symbol
    build_letter("--..");
    run_stim(nv, ne, fl, ve);
    check("Z before reset", letter_code, 7);
    drive_raw(1'b1, U);
    drive_raw(1'b0, U);
    drive_raw(1'b1, 4);
    #2 reset = 1'b1;
    #1 check("async reset outputs", {letter_code, letter_valid, error, busy}, 0);
    morse_in = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock) reset = 1'b0;
    model_code = 0;
    build_letter("...-");
    run_stim(nv, ne, fl, ve);
    check("V after reset valid", nv, 1);
    check("V after reset code", letter_code, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
